// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: run-mode encodings and controller state enum
package cpu_ctrl_pkg;
  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST,
    ST_DONE,
    ST_BREAK
  } state_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running counter that fires once every 2^(SHIFT+divide) enabled cycles
module tick_prescaler #(
  parameter int SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] divide,
  output logic       rateTick
);
  localparam int PW = SHIFT + 15;
  logic [PW-1:0] count_q, count_d, mask;
  always_comb begin
    mask = ~({PW{1'b1}} << (SHIFT + 32'(divide)));
    count_d = clear ? '0 : enable ? count_q + PW'(1) : count_q;
    rateTick = enable && ((count_q & mask) == mask);
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: generates CPU clock-enable pulses for run, single-step and burst modes with a PC breakpoint
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int SHIFT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [3:0]       divide,
  input  logic             stepBtn,
  input  logic [7:0]       burstCount,
  input  logic             bpEnable,
  input  logic [31:0]      bpAddr,
  input  logic [31:0]      pc,
  output logic             cpuTick,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycleCount
);
  state_e state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic step_prev_q, cpu_tick_q, running_q, halted_q;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic tick_d, rate_tick, active, bp_hit, step_edge;
  assign active = (state_q == ST_RUN) || (state_q == ST_BURST);
  assign bp_hit = rate_tick && bpEnable && (pc == bpAddr);
  assign step_edge = stepBtn && !step_prev_q;
  // Holding clear outside RUN/BURST guarantees a zeroed count on every entry.
  tick_prescaler #(.SHIFT(SHIFT)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (!active),
    .enable   (active),
    .divide   (divide),
    .rateTick (rate_tick)
  );
  always_comb begin
    state_d = state_q;
    remaining_d = remaining_q;
    tick_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RUN) state_d = ST_RUN;
        else if (mode == MODE_BURST) begin
          state_d = (burstCount != 8'd0) ? ST_BURST : ST_DONE;
          remaining_d = burstCount;
        end else if (mode == MODE_STEP) tick_d = step_edge;
      end
      ST_RUN: begin
        if (bp_hit) state_d = ST_BREAK;
        else if (mode != MODE_RUN) state_d = ST_IDLE;
        else tick_d = rate_tick;
      end
      ST_BURST: begin
        if (bp_hit) state_d = ST_BREAK;
        else if (mode != MODE_BURST) state_d = ST_IDLE;
        else if (rate_tick) begin
          tick_d = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d = (remaining_q == 8'd1) ? ST_DONE : ST_BURST;
        end
      end
      ST_DONE: state_d = (mode != MODE_BURST) ? ST_IDLE : ST_DONE;
      ST_BREAK: state_d = (mode == MODE_HALT) ? ST_IDLE : ST_BREAK;
      default: state_d = ST_IDLE;
    endcase
    cycle_count_d = tick_d ? cycle_count_q + CNT_W'(1) : cycle_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      remaining_q <= 8'd0;
      step_prev_q <= 1'b0;
      cpu_tick_q <= 1'b0;
      running_q <= 1'b0;
      halted_q <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      step_prev_q <= stepBtn;
      cpu_tick_q <= tick_d;
      running_q <= (state_d == ST_RUN) || (state_d == ST_BURST);
      halted_q <= state_d == ST_BREAK;
      cycle_count_q <= cycle_count_d;
    end
  end
  assign cpuTick = cpu_tick_q;
  assign running = running_q;
  assign halted = halted_q;
  assign cycleCount = cycle_count_q;
endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter SHIFT, default 16, meaning base prescaler exponent; the tick period is 2^(SHIFT+divide) clk cycles.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of cycleCount.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mode  input  2  run mode: 00 HALT, 01 RUN, 10 STEP, 11 BURST; already synchronized.
REQ-006 SHALL have port divide  input  4  prescaler exponent offset; already synchronized.
REQ-007 SHALL have port stepBtn  input  1  single-step request, level, already debounced.
REQ-008 SHALL have port burstCount  input  8  number of ticks per burst.
REQ-009 SHALL have port bpEnable  input  1  breakpoint enable.
REQ-010 SHALL have port bpAddr  input  32  breakpoint PC value.
REQ-011 SHALL have port pc  input  32  current CPU program counter.
REQ-012 SHALL have port cpuTick  output  1  registered one-clk CPU clock-enable pulse.
REQ-013 SHALL have port running  output  1  registered; high in RUN or BURST.
REQ-014 SHALL have port halted  output  1  registered; high in BREAK.
REQ-015 SHALL have port cycleCount  output  CNT_W  count of issued cpuTick pulses.

Function
REQ-016 SHALL implement states IDLE, RUN, BURST, DONE, BREAK.
REQ-017 SHALL clear the prescaler on every entry to RUN or BURST and advance it only in those states; rateTick fires when the low SHIFT+divide bits are all ones, so the first tick comes 2^(SHIFT+divide) cycles after entry.
REQ-018 IDLE SHALL go to RUN on mode 01.
REQ-019 IDLE SHALL go to BURST on mode 11 when burstCount is not 0, loading remaining = burstCount; with burstCount 0 it SHALL go to DONE.
REQ-020 In IDLE with mode 10, each rising edge of stepBtn SHALL produce exactly one cpuTick on the following cycle; held levels SHALL produce no further ticks.
REQ-021 RUN SHALL assert cpuTick for one cycle after each rateTick, and SHALL return to IDLE when mode is not 01, with no tick in that cycle.
REQ-022 BURST SHALL tick on rateTick and decrement remaining; after the tick that brings remaining to 0 it SHALL go to DONE.
REQ-023 BURST SHALL abort to IDLE when mode is not 11.
REQ-024 DONE SHALL issue no ticks and SHALL go to IDLE when mode is not 11, so a burst never retriggers while mode is held at 11.
REQ-025 In RUN or BURST, if bpEnable is high and pc equals bpAddr in a rateTick cycle, the tick SHALL be suppressed and the state SHALL go to BREAK; breakpoint takes priority over a mode change in the same cycle.
REQ-026 BREAK SHALL issue no ticks, ignore stepBtn, and go to IDLE only when mode is 00.
REQ-027 cycleCount SHALL increment by 1 per cpuTick and wrap modulo 2^CNT_W.
REQ-028 The stepBtn edge detector's previous-value register SHALL update in every state, so an edge occurring outside IDLE/STEP is discarded.

Reset
REQ-029 With rst high at a clk edge: state IDLE, prescaler 0, remaining 0, previous stepBtn 0, cpuTick 0, running 0, halted 0, cycleCount 0.
REQ-030 Reset mid-burst or in BREAK SHALL abandon the operation; no tick SHALL be issued in the cycle after reset.

Structure
REQ-031 Package cpu_ctrl_pkg SHALL hold the mode encodings (MODE_HALT/RUN/STEP/BURST) and the state enum.
REQ-032 One sub-module, tick_prescaler (clk, rst, clear, enable, divide -> rateTick), parameterized by SHIFT, SHALL implement the prescaler.

Verification (SHIFT=2)
REQ-033 divide=0, mode=01 for 40 cycles -> cpuTick every 4 cycles, first at cycle 4, cycleCount=10; mode=00 -> no further ticks.
REQ-034 mode=11, burstCount=3, divide=1 -> exactly 3 ticks spaced 8 cycles, then DONE; holding mode 11 for 100 cycles -> cycleCount stays 3.
REQ-035 mode=10, stepBtn high for 20 cycles, low, high again -> exactly 2 ticks, each one cycle after its rising edge.
REQ-036 mode=01, bpEnable=1, bpAddr=0x10, pc steps +4 per tick from 0 -> 4 ticks, then halted=1 with no tick at pc=0x10; mode=00 -> IDLE, halted=0.
REQ-037 rst pulsed during burst with remaining=2 -> all outputs 0 the next cycle and no tick until mode re-entry.
REQ-038 cycleCount preloaded via CNT_W=4 at 15 -> the next tick wraps it to 0.
